lmc_core: RTL

//  Parametrised Little Man Computer core: program counter, unified data/program RAM, accumulator, ALU.

---
 rtl/lmc_core.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/lmc_core.sv
// lmc_core: Little Man Computer core with PC, unified RAM, accumulator and ALU.
// Ports: timer555/reset_n clock+async reset; start/prog_* program control;
//   in_* and out_* ready/valid I/O; acc, pc, halted status.
//   Optional LMC_STEP_EN macro adds a 'step' input that gates instruction fetch.
module lmc_core #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  timer555,
  input  logic                  reset_n,
  input  logic                  start,
`ifdef LMC_STEP_EN
  input  logic                  step,
`endif
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] acc,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  localparam logic [3:0] OP_HLT = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_STA = 4'd3;
  localparam logic [3:0] OP_LDA = 4'd5;
  localparam logic [3:0] OP_BRA = 4'd6;
  localparam logic [3:0] OP_BRZ = 4'd7;
  localparam logic [3:0] OP_BRP = 4'd8;
  localparam logic [3:0] OP_INP = 4'd9;
  localparam logic [3:0] OP_OUT = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WAIT_IN,
    S_WAIT_OUT,
    S_HALT
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  neg_q, neg_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic [3:0]            op;
  logic [ADDR_WIDTH-1:0] opa;
  logic [DATA_WIDTH-1:0] m_ir;
  logic [DATA_WIDTH-1:0] m_rd;
  logic [DATA_WIDTH:0]   diff;
  logic                  go;

  assign op   = ir_q[DATA_WIDTH-1 -: 4];
  assign opa  = ir_q[ADDR_WIDTH-1:0];
  assign m_ir = mem[pc_q];
  assign m_rd = mem[opa];
  // Extra top bit of the difference is the borrow.
  assign diff = {1'b0, acc_q} - {1'b0, m_rd};

`ifdef LMC_STEP_EN
  assign go = step;
`else
  assign go = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    acc_d     = acc_q;
    ir_d      = ir_q;
    out_d     = out_q;
    neg_d     = neg_q;
    mem_we    = 1'b0;
    mem_waddr = prog_addr;
    mem_wdata = prog_data;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        mem_we = prog_we;
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          acc_d   = '0;
          neg_d   = 1'b0;
        end
      end
      S_FETCH: begin
        if (go) begin
          ir_d    = m_ir;
          pc_d    = pc_q + ADDR_WIDTH'(1);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          OP_HLT: state_d = S_HALT;
          OP_ADD: begin
            acc_d = acc_q + m_rd;
            neg_d = 1'b0;
          end
          OP_SUB: begin
            acc_d = diff[DATA_WIDTH-1:0];
            neg_d = diff[DATA_WIDTH];
          end
          OP_STA: begin
            mem_we    = 1'b1;
            mem_waddr = opa;
            mem_wdata = acc_q;
          end
          OP_LDA: begin
            acc_d = m_rd;
            neg_d = 1'b0;
          end
          OP_BRA: pc_d = opa;
          OP_BRZ: if (acc_q == '0) pc_d = opa;
          OP_BRP: if (!neg_q) pc_d = opa;
          OP_INP: state_d = S_WAIT_IN;
          OP_OUT: begin
            out_d   = acc_q;
            state_d = S_WAIT_OUT;
          end
          default: ;
        endcase
      end
      S_WAIT_IN: begin
        if (in_valid) begin
          acc_d   = in_data;
          neg_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_WAIT_OUT: begin
        if (out_ready) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge timer555 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      acc_q   <= '0;
      ir_q    <= '0;
      out_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
      out_q   <= out_d;
      neg_q   <= neg_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge timer555) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign in_ready  = (state_q == S_WAIT_IN);
  assign out_valid = (state_q == S_WAIT_OUT);
  assign halted    = (state_q == S_HALT);
  assign out_data  = out_q;
  assign acc       = acc_q;
  assign pc        = pc_q;

endmodule
